// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter: picks one of N requesters, drives the shared
// register bank's d/en for one cycle, then acknowledges the winner.
module reg_write_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [W-1:0]         reg_d,
  output logic                 reg_en,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(N)-1:0] last_id
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [W-1:0]    reg_d_q, reg_d_d;
  logic            reg_en_q, reg_en_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   last_id_q, last_id_d;

  logic            found;
  logic [IW-1:0]   win_idx;

  // (base + off) mod N; N need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First pending requester at or above ptr, wrapping past N-1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found   = 1'b0;
    win_idx = '0;
    for (int off = 0; off < N; off++) begin
      if (!found && req[rr_index(ptr_q, off)]) begin
        found   = 1'b1;
        win_idx = rr_index(ptr_q, off);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    grant_d   = grant_q;
    reg_d_d   = reg_d_q;
    reg_en_d  = 1'b0;
    ack_d     = '0;
    busy_d    = busy_q;
    last_id_d = last_id_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = win_idx;
          grant_d = onehot(win_idx);
          reg_d_d = wdata[int'(win_idx)*W +: W];
          busy_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        reg_en_d = 1'b1;
        state_d  = ACK;
      end
      ACK: begin
        // First ACK cycle raises the pulse; the second one retires the transaction.
        if (ack_q == '0) begin
          ack_d = grant_q;
        end else begin
          ptr_d     = rr_index(win_q, 1);
          last_id_d = win_q;
          grant_d   = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      grant_q   <= '0;
      reg_d_q   <= '0;
      reg_en_q  <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      last_id_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      grant_q   <= grant_d;
      reg_d_q   <= reg_d_d;
      reg_en_q  <= reg_en_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      last_id_q <= last_id_d;
    end
  end

  assign reg_d   = reg_d_q;
  assign reg_en  = reg_en_q;
  assign grant   = grant_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a transaction-level model predicts
// each write and ack; a negedge monitor pops and compares what the DUT shows.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   reg_d;
  logic           reg_en;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           busy;
  logic [1:0]     last_id;

  reg_write_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .reg_d   (reg_d),
    .reg_en  (reg_en),
    .grant   (grant),
    .ack     (ack),
    .busy    (busy),
    .last_id (last_id)
  );

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         wq[$];
  exp_t         aq[$];
  logic [N-1:0] grant_log[$];
  int           en_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an idle arbiter grants the first pending requester from
  // its pointer; the write shows 1 edge later, the ack 2 edges later, and the
  // arbiter may grant again 4 edges after the grant edge.
  int mptr      = 0;
  int next_free = 0;
  always @(posedge clk) begin
    int w;
    cyc++;
    if (!rst) begin
      mptr      = 0;
      next_free = 0;
    end else if (cyc >= next_free && req != '0) begin
      w = -1;
      for (int o = 0; o < N; o++)
        if (w < 0 && req[(mptr + o) % N]) w = (mptr + o) % N;
      wq.push_back('{id: w, data: wdata[w*W +: W], cyc: cyc + 1});
      aq.push_back('{id: w, data: '0, cyc: cyc + 2});
      mptr      = (w + 1) % N;
      next_free = cyc + 4;
    end
  end

  // Monitor: compares DUT activity against the queued expectations.
  int   pend_id;
  int   pend_cyc;
  bit   pend_valid = 1'b0;
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] vec;
    if (!rst) begin
      wq.delete();
      aq.delete();
      pend_valid = 1'b0;
    end else begin
      check("grant_onehot", 32'($countones(grant) <= 1), 1);
      if (reg_en) begin
        grant_log.push_back(grant);
        en_log.push_back(cyc);
        check("reg_en_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          vec = '0;
          vec[e.id] = 1'b1;
          check("reg_en_cycle", cyc, e.cyc);
          check("reg_en_grant", grant, vec);
          check("reg_en_data", reg_d, e.data);
        end
      end
      if (ack != '0) begin
        check("ack_expected", 32'(aq.size() > 0), 1);
        if (aq.size() > 0) begin
          e = aq.pop_front();
          vec = '0;
          vec[e.id] = 1'b1;
          check("ack_cycle", cyc, e.cyc);
          check("ack_vector", ack, vec);
          pend_id    = e.id;
          pend_cyc   = cyc + 1;
          pend_valid = 1'b1;
        end
      end else if (pend_valid && cyc == pend_cyc) begin
        check("last_id", last_id, pend_id);
        check("busy_after_ack", busy, 0);
        check("grant_after_ack", grant, 0);
        pend_valid = 1'b0;
      end
    end
  end

  task automatic wait_acks(input int n, input bit autodrop);
    int got    = 0;
    int budget = n * 8 + 20;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack != '0) begin
        got++;
        if (autodrop) req = req & ~ack;
      end
    end
    check("acks_seen", got, n);
  endtask

  task automatic check_log(input string name, input logic [N-1:0] exp_vec[$]);
    check({name, "_len"}, grant_log.size(), exp_vec.size());
    for (int i = 0; i < exp_vec.size() && i < grant_log.size(); i++)
      check(name, grant_log[i], exp_vec[i]);
  endtask

  initial begin
    logic [N-1:0] exp_vec[$];
    rst   = 1'b0;
    req   = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'(8'h10 + i);
    req = 4'b1111;

    // Reset held with every requester pending: everything stays cleared.
    repeat (3) @(negedge clk);
    check("rst_reg_d", reg_d, 0);
    check("rst_reg_en", reg_en, 0);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_last_id", last_id, 0);

    // Round robin with all four requesters held high.
    grant_log.delete();
    en_log.delete();
    rst = 1'b1;
    @(negedge clk);
    check("first_grant", grant, 4'b0001);
    wait_acks(5, 1'b0);
    req = '0;
    exp_vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check_log("rr_order", exp_vec);
    for (int i = 0; i + 1 < en_log.size(); i++)
      check("rr_en_spacing", en_log[i+1] - en_log[i], 4);
    repeat (4) @(negedge clk);

    // Single request from requester 2.
    wdata[2*W +: W] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    check("single_grant", grant, 4'b0100);
    check("single_reg_d", reg_d, 8'hA5);
    check("single_busy", busy, 1);
    check("single_en_early", reg_en, 0);
    @(negedge clk);
    check("single_en", reg_en, 1);
    @(negedge clk);
    check("single_en_drop", reg_en, 0);
    check("single_ack", ack, 4'b0100);
    req = '0;
    @(negedge clk);
    check("single_last_id", last_id, 2);
    check("single_ack_drop", ack, 0);
    check("single_idle", busy, 0);

    // Pointer wrap after requester 3, then 0 is skipped.
    req = 4'b1000;
    wait_acks(1, 1'b1);
    grant_log.delete();
    req = 4'b0110;
    wait_acks(2, 1'b1);
    exp_vec = '{4'b0010, 4'b0100};
    check_log("wrap_order", exp_vec);
    repeat (2) @(negedge clk);

    // Committed write: request dropped and data changed after the grant.
    wdata[1*W +: W] = 8'h3C;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wdata[1*W +: W] = 8'hFF;
    @(negedge clk);
    check("commit_en", reg_en, 1);
    check("commit_reg_d", reg_d, 8'h3C);
    @(negedge clk);
    check("commit_ack", ack, 4'b0010);
    check("commit_reg_d_hold", reg_d, 8'h3C);
    repeat (3) @(negedge clk);

    // Reset while the write enable is up.
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check("midrst_en_before", reg_en, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_en", reg_en, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ack", ack, 0);
    end
    grant_log.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_restart", grant, 4'b0001);
    wait_acks(4, 1'b1);
    exp_vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    check_log("midrst_order", exp_vec);

    // Randomised traffic; some requesters stay up after their ack.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else wdata[i*W +: W] = 8'($urandom);
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          wdata[i*W +: W] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end

    // Drain: no new requests, pending ones retire on their ack.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      req = req & ~ack;
      if (req == '0) break;
    end
    repeat (6) @(negedge clk);
    check("drain_req", req, 0);
    check("drain_wq", wq.size(), 0);
    check("drain_aq", aq.size(), 0);
    check("drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one enable-gated register bank (the `d_flipflop`-style storage, driven through its `d`/`en` inputs) among N requesters. It accepts write requests, picks one winner per transaction, and drives the shared register's data and enable for exactly one cycle. It then acknowledges the winner. It sits between the requesting agents and the register bank; the bank itself is outside this block.

## Interface
- `N`, default 4: number of requesters; legal range 2..8.
- `W`, default 8: data width of the shared register.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `req`  input  N  request per requester; bit i is held high until `ack[i]`.
- `wdata`  input  N*W  packed write data; slice i is `wdata[i*W +: W]` and is valid while `req[i]` is high.
- `reg_d`  output  W  data to the shared register bank.
- `reg_en`  output  1  write enable to the shared register bank.
- `grant`  output  N  one-hot winner of the current transaction; zero when idle.
- `ack`  output  N  one-cycle completion pulse to the winner.
- `busy`  output  1  high while a transaction is in flight.
- `last_id`  output  clog2(N)  index of the most recently acknowledged requester.

## Operation
- FSM states are IDLE, WRITE and ACK. Reset puts the FSM in IDLE.
- **IDLE**
  - If `req` is 0, the FSM stays in IDLE.
  - Otherwise, the winner is the first set bit of `req`, searching upward from `ptr` and wrapping from N-1 to 0.
  - On the transition: register `grant` as the one-hot of the winner, latch the winner's `wdata` slice into `reg_d`, set `busy`=1, and go to WRITE.
- **WRITE**
  - `reg_en`=1 for this single cycle.
  - `reg_d` and `grant` hold their values.
  - The FSM goes to ACK unconditionally.
  - The write is committed: a requester dropping `req` or changing `wdata` during WRITE has no effect.
- **ACK**
  - `ack[winner]`=1 and `reg_en`=0.
  - On exit:
    - set `ptr` to (winner+1) mod N;
    - set `last_id` to the winner;
    - clear `grant` and `busy`;
    - go to IDLE.
- Round-robin fairness: a requester that keeps `req` high after its ack is re-arbitrated behind every other pending requester.
- Requests that arrive while the FSM is not in IDLE wait; they are never lost as long as `req` is held.
- `ptr` is an internal clog2(N)-bit register; values of N that are not a power of 2 wrap explicitly at N-1.
- Simultaneous requests: exactly one grant per transaction; `grant` is never multi-hot.
- **Reset** (any time, including mid-transaction), asynchronously forces:
  - FSM to IDLE and `ptr`=0;
  - `reg_en`=0, `reg_d`=0, `grant`=0, `ack`=0, `busy`=0, `last_id`=0.
  - An interrupted write is not retried.

## Timing
- All outputs are registered; there is no combinational path from `req`/`wdata` to any output.
- Transaction timeline, where `req` is sampled high in IDLE at edge k:
  - after edge k: `grant`, `reg_d` and `busy` are valid;
  - after edge k+1: `reg_en` is high for one cycle, so the bank captures `reg_d` at edge k+2;
  - after edge k+2: `ack` is high for one cycle;
  - after edge k+3: the FSM is in IDLE and `busy` is low.
- Each transaction takes 3 cycles from the grant edge back to IDLE. Sustained throughput is one write per 4 cycles.
- `reg_d` stays stable from the grant edge until the next grant or reset.
- Release of reset is synchronous to `clk` at the system level. The first arbitration happens at the first rising edge with `rst` high.

## Test plan
- **Reset values:** hold `rst`=0 with `req`=4'b1111 → all outputs 0 and no `reg_en`. Release reset → first grant goes to requester 0.
- **Single request:** `req`=4'b0100 with slice 2 = 8'hA5 → `grant`=4'b0100 and `reg_d`=8'hA5 after 1 edge. `reg_en` is high for exactly the next cycle, `ack`=4'b0100 the cycle after, then `last_id`=2.
- **Round-robin:** `req`=4'b1111 held continuously, each requester with distinct data → grant order 0, 1, 2, 3, 0. Each `reg_en` pulse carries that requester's data, and the `reg_en` pulses are 4 cycles apart.
- **Pointer wrap and skip:** after requester 3 is acked, `req`=4'b0110 → requester 1 wins, then requester 2. Requester 0 is never granted.
- **Committed write:** drop `req[1]` and change `wdata` during WRITE → `reg_d` keeps the latched value and `ack[1]` still pulses.
- **Reset mid-transaction:** assert `rst`=0 during WRITE → `reg_en`, `grant` and `busy` drop immediately without waiting for a clock, and no `ack` is produced. After release, arbitration restarts from `ptr`=0.
